queue: RTL and testbench

Synchronous single-clock FIFO queue for byte-wide data between producer and consumer logic in the USB device datapath, e.g. endpoint buffering. Words are written with a write enable and read with a read enable. The read data port is registered and updates on the edge that accepts a read. Empty/full status is combinational from an occupancy counter and always exact.

---
 rtl/queue_pkg.sv | 12 +
 rtl/queue_ram.sv | 38 +++
 rtl/queue.sv | 95 +++++++++
 tb/tb_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared defaults and pointer-width helper for the queue FIFO and its storage.
package queue_pkg;

  localparam int QUEUE_DEFAULT_SIZE  = 256;
  localparam int QUEUE_DEFAULT_WIDTH = 8;

  // Index width for a DEPTH-entry array; never narrower than one bit.
  function automatic int queue_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/queue_ram.sv
// Simple dual-port word store: synchronous write, registered synchronous read.
// Latency: read data appears on rdata right after the edge with re high.
// Backpressure: none; the caller only asserts we/re for accepted operations.
module queue_ram
  import queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEFAULT_SIZE,
  parameter int WIDTH = QUEUE_DEFAULT_WIDTH,
  parameter int AW    = queue_ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; stale words are unreachable after rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/queue.sv
// Single-clock FIFO with exact empty/full/count; optional sticky error flags via QUEUE_ERR_FLAGS_EN.
// Latency: word written at edge N is poppable at edge N+1; data_out registered on the read edge.
// Backpressure: writes dropped when full unless a read is accepted the same cycle; reads ignored when empty.
module queue
  import queue_pkg::*;
#(
  parameter int SIZE  = QUEUE_DEFAULT_SIZE,
  parameter int WIDTH = QUEUE_DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic                       full,
`ifdef QUEUE_ERR_FLAGS_EN
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [$clog2(SIZE+1)-1:0]  count
);

  localparam int AW = queue_ptr_width(SIZE);
  localparam int CW = $clog2(SIZE + 1);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_acc;
  logic          wr_acc;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(SIZE));
  assign rd_acc = r_en && !empty;
  // A full queue still takes a write when a read frees a slot on the same edge.
  assign wr_acc = w_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= ptr_inc(wptr);
      end
      if (rd_acc) begin
        rptr <= ptr_inc(rptr);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full && !rd_acc) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

  queue_ram #(
    .DEPTH (SIZE),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_queue.sv
// Directed bench for queue: a default-size instance and an 8-deep instance, hand-computed expectations.
module tb_queue;

  logic clk = 1'b0;
  logic rst;

  logic       b_w_en, b_r_en;
  logic [7:0] b_din, b_dout;
  logic       b_empty, b_full;
  logic [8:0] b_count;

  logic       s_w_en, s_r_en;
  logic [7:0] s_din, s_dout;
  logic       s_empty, s_full;
  logic [3:0] s_count;

`ifdef QUEUE_ERR_FLAGS_EN
  logic b_ovf, b_unf, s_ovf, s_unf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  queue u_big (
    .clk       (clk),
    .rst       (rst),
    .w_en      (b_w_en),
    .data_in   (b_din),
    .r_en      (b_r_en),
    .data_out  (b_dout),
    .empty     (b_empty),
    .full      (b_full),
`ifdef QUEUE_ERR_FLAGS_EN
    .overflow  (b_ovf),
    .underflow (b_unf),
`endif
    .count     (b_count)
  );

  queue #(.SIZE(8), .WIDTH(8)) u_small (
    .clk       (clk),
    .rst       (rst),
    .w_en      (s_w_en),
    .data_in   (s_din),
    .r_en      (s_r_en),
    .data_out  (s_dout),
    .empty     (s_empty),
    .full      (s_full),
`ifdef QUEUE_ERR_FLAGS_EN
    .overflow  (s_ovf),
    .underflow (s_unf),
`endif
    .count     (s_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b_w_en = 1'b0; b_r_en = 1'b0; b_din = '0;
    s_w_en = 1'b0; s_r_en = 1'b0; s_din = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_b_dout",  32'(b_dout),  32'h0);
    check("rst_b_count", 32'(b_count), 32'h0);
    check("rst_b_empty", 32'(b_empty), 32'h1);
    check("rst_b_full",  32'(b_full),  32'h0);
    check("rst_s_empty", 32'(s_empty), 32'h1);
    check("rst_s_full",  32'(s_full),  32'h0);

    // Default depth: 9 writes then 9 reads.
    for (int i = 1; i <= 9; i++) begin
      b_w_en = 1'b1; b_din = 8'(i);
      tick();
      if (i == 1) check("b_empty_fall", 32'(b_empty), 32'h0);
    end
    b_w_en = 1'b0;
    check("b_count9", 32'(b_count), 32'd9);
    for (int i = 1; i <= 9; i++) begin
      b_r_en = 1'b1;
      tick();
      check("b_rd", 32'(b_dout), 32'(i));
    end
    b_r_en = 1'b0;
    check("b_empty_end", 32'(b_empty), 32'h1);
    check("b_count_end", 32'(b_count), 32'h0);

    // Depth 8: ninth write hits a full queue and is dropped.
    for (int i = 1; i <= 9; i++) begin
      s_w_en = 1'b1; s_din = 8'(i);
      tick();
      if (i == 7) check("s_full_7", 32'(s_full), 32'h0);
      if (i == 8) check("s_full_8", 32'(s_full), 32'h1);
    end
    s_w_en = 1'b0;
    check("s_count8", 32'(s_count), 32'd8);
`ifdef QUEUE_ERR_FLAGS_EN
    check("s_ovf_set",  32'(s_ovf), 32'h1);
    check("s_unf_idle", 32'(s_unf), 32'h0);
`endif
    for (int i = 1; i <= 8; i++) begin
      s_r_en = 1'b1;
      tick();
      check("s_rd", 32'(s_dout), 32'(i));
    end
    s_r_en = 1'b0;
    check("s_empty_8", 32'(s_empty), 32'h1);

    // Read while empty: ignored, data_out holds.
    s_r_en = 1'b1;
    tick();
    s_r_en = 1'b0;
    check("s_rd_empty_hold", 32'(s_dout),  32'h8);
    check("s_rd_empty_cnt",  32'(s_count), 32'h0);
`ifdef QUEUE_ERR_FLAGS_EN
    check("s_unf_set", 32'(s_unf), 32'h1);
`endif

    // 20 writes with reads trailing by 3 cycles; pointers wrap past 8.
    for (int t = 0; t < 23; t++) begin
      s_w_en = (t < 20);
      s_din  = 8'(t + 16);
      s_r_en = (t >= 3);
      tick();
      if (t >= 3) check("wrap_rd", 32'(s_dout), 32'(t - 3 + 16));
      if (t == 10) check("wrap_cnt", 32'(s_count), 32'd3);
    end
    s_w_en = 1'b0; s_r_en = 1'b0;
    check("wrap_empty", 32'(s_empty), 32'h1);

    // Reset mid-operation, with a write asserted during reset.
    for (int i = 0; i < 5; i++) begin
      s_w_en = 1'b1; s_din = 8'(8'h60 + i);
      tick();
    end
    check("pre_rst_cnt", 32'(s_count), 32'd5);
    rst = 1'b1; s_din = 8'h77;
    tick();
    rst = 1'b0; s_w_en = 1'b0;
    check("rst_mid_cnt",  32'(s_count), 32'h0);
    check("rst_mid_dout", 32'(s_dout),  32'h0);
`ifdef QUEUE_ERR_FLAGS_EN
    check("rst_ovf_clr", 32'(s_ovf), 32'h0);
    check("rst_unf_clr", 32'(s_unf), 32'h0);
`endif
    s_r_en = 1'b1;
    tick();
    s_r_en = 1'b0;
    check("rst_rd_empty", 32'(s_empty), 32'h1);
    check("rst_rd_dout",  32'(s_dout),  32'h0);

    // Full queue with simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      s_w_en = 1'b1; s_din = 8'(8'h21 + i);
      tick();
    end
    check("full_pre", 32'(s_full), 32'h1);
    s_w_en = 1'b1; s_r_en = 1'b1; s_din = 8'hAA;
    tick();
    s_w_en = 1'b0; s_r_en = 1'b0;
    check("full_rw_dout", 32'(s_dout),  32'h21);
    check("full_rw_full", 32'(s_full),  32'h1);
    check("full_rw_cnt",  32'(s_count), 32'd8);
`ifdef QUEUE_ERR_FLAGS_EN
    check("full_rw_no_ovf", 32'(s_ovf), 32'h0);
`endif
    for (int i = 0; i < 8; i++) begin
      s_r_en = 1'b1;
      tick();
      check("full_drain", 32'(s_dout), (i == 7) ? 32'hAA : 32'(8'h22 + i));
    end
    s_r_en = 1'b0;

    // Simultaneous read and write on empty: write only, no fall-through.
    s_w_en = 1'b1; s_r_en = 1'b1; s_din = 8'h55;
    tick();
    s_w_en = 1'b0; s_r_en = 1'b0;
    check("empty_rw_cnt",  32'(s_count), 32'd1);
    check("empty_rw_dout", 32'(s_dout),  32'hAA);
    s_r_en = 1'b1;
    tick();
    s_r_en = 1'b0;
    check("empty_rw_rd", 32'(s_dout), 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
